// File: rtl/seq_code_tx.sv
// Transmitter that walks a downstream detector between levels s0/s1/s2 by emitting one-hot codes.
// Optional macro SEQ_CODE_TX_SRST_EN adds a soft-reset pulse output (srst_out) used for target=3.
module seq_code_tx #(
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       start,
    input  logic [1:0] target,
    output logic [3:0] dout,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_mdl,
    output logic [7:0] q_exp
`ifdef SEQ_CODE_TX_SRST_EN
    ,
    output logic       srst_out
`endif
);

    localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
    localparam logic [3:0] GAP_LD  = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] dout_q;
    logic [3:0] code2_q;
    logic       has2_q;
    logic       busy_q;
    logic       done_q;
    logic [1:0] mdl_q;

    logic       plan_noop;
    logic [3:0] plan_c1;
    logic [3:0] plan_c2;
    logic       plan_two;
`ifdef SEQ_CODE_TX_SRST_EN
    logic       plan_srst;
    logic       srst_q;
`endif

    // Level reached once a code has been fully held; 0 (soft reset) lands on s0.
    function automatic logic [1:0] code_dest(input logic [3:0] c);
        case (c)
            4'h1:    code_dest = 2'd1;
            4'h2:    code_dest = 2'd2;
            4'h4:    code_dest = 2'd1;
            default: code_dest = 2'd0;
        endcase
    endfunction

    // Code plan for the command presented on target, relative to the current model level.
    always_comb begin
        plan_noop = 1'b0;
        plan_c1   = 4'h0;
        plan_c2   = 4'h0;
        plan_two  = 1'b0;
`ifdef SEQ_CODE_TX_SRST_EN
        plan_srst = 1'b0;
`endif
        if (target == 2'd3) begin
`ifdef SEQ_CODE_TX_SRST_EN
            plan_srst = 1'b1;
`else
            plan_noop = 1'b1;
`endif
        end else if (target == mdl_q) begin
            plan_noop = 1'b1;
        end else begin
            case ({mdl_q, target})
                4'b00_01: plan_c1 = 4'h1;
                4'b01_10: plan_c1 = 4'h2;
                4'b10_01: plan_c1 = 4'h4;
                4'b10_00: plan_c1 = 4'h8;
                4'b00_10: begin plan_c1 = 4'h1; plan_c2 = 4'h2; plan_two = 1'b1; end
                4'b01_00: begin plan_c1 = 4'h2; plan_c2 = 4'h8; plan_two = 1'b1; end
                default:  plan_noop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 4'h0;
            code2_q <= 4'h0;
            has2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mdl_q   <= 2'd0;
`ifdef SEQ_CODE_TX_SRST_EN
            srst_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (plan_noop) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE;
                            busy_q  <= 1'b1;
                            dout_q  <= plan_c1;
                            code2_q <= plan_c2;
                            has2_q  <= plan_two;
                            cnt_q   <= HOLD_LD;
`ifdef SEQ_CODE_TX_SRST_EN
                            srst_q  <= plan_srst;
`endif
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        mdl_q  <= code_dest(dout_q);
                        dout_q <= 4'h0;
`ifdef SEQ_CODE_TX_SRST_EN
                        srst_q <= 1'b0;
`endif
                        if (GAP_CYC != 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                        end else if (has2_q) begin
                            dout_q  <= code2_q;
                            has2_q  <= 1'b0;
                            cnt_q   <= HOLD_LD;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (has2_q) begin
                        state_q <= DRIVE;
                        dout_q  <= code2_q;
                        has2_q  <= 1'b0;
                        cnt_q   <= HOLD_LD;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_mdl = mdl_q;
    assign q_exp     = (mdl_q == 2'd1) ? 8'h55 : (mdl_q == 2'd2) ? 8'hFF : 8'h00;
`ifdef SEQ_CODE_TX_SRST_EN
    assign srst_out  = srst_q;
`endif

endmodule

// File: tb/tb_seq_code_tx.sv
// Randomized bench for seq_code_tx against a per-cycle expected-output queue built from the code plan rules.
module tb_seq_code_tx;

    localparam int HOLD = 1;
    localparam int GAP  = 2;

    logic       clk;
    logic       rst_in;
    logic       start;
    logic [1:0] target;
    logic [3:0] dout;
    logic       busy;
    logic       done;
    logic [1:0] state_mdl;
    logic [7:0] q_exp;
    logic       srst_out;

    seq_code_tx #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .start     (start),
        .target    (target),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .state_mdl (state_mdl),
        .q_exp     (q_exp)
`ifdef SEQ_CODE_TX_SRST_EN
        ,
        .srst_out  (srst_out)
`endif
    );
`ifndef SEQ_CODE_TX_SRST_EN
    assign srst_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dout;
        logic       busy;
        logic       done;
        logic [1:0] mdl;
        logic       srst;
    } exp_t;

    exp_t q[$];
    int   mdl_m;
    bit   idle_m;
    int   errors;
    int   checks;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] hop_code(input int a, input int b);
        if (a == 0 && b == 1) return 4'h1;
        if (a == 1 && b == 2) return 4'h2;
        if (a == 2 && b == 1) return 4'h4;
        return 4'h8;
    endfunction

    function automatic logic [7:0] level_q(input int m);
        case (m)
            1:       return 8'h55;
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_gap(input int cur);
        for (int g = 0; g < GAP; g++) q.push_back({4'h0, 1'b1, 1'b0, 2'(cur), 1'b0});
    endtask

    // Expand one accepted command into its full cycle-by-cycle output sequence.
    task automatic push_plan(input int t);
        int cur;
        int path[$];
        cur = mdl_m;
        if (t == 3) begin
`ifdef SEQ_CODE_TX_SRST_EN
            for (int h = 0; h < HOLD; h++) q.push_back({4'h0, 1'b1, 1'b0, 2'(cur), 1'b1});
            cur = 0;
            push_gap(cur);
`endif
        end else if (t != cur) begin
            if (cur == 0 && t == 2)      path = '{1, 2};
            else if (cur == 1 && t == 0) path = '{2, 0};
            else                         path = '{t};
            foreach (path[i]) begin
                for (int h = 0; h < HOLD; h++)
                    q.push_back({hop_code(cur, path[i]), 1'b1, 1'b0, 2'(cur), 1'b0});
                cur = path[i];
                push_gap(cur);
            end
        end
        q.push_back({4'h0, 1'b0, 1'b1, 2'(cur), 1'b0});
        mdl_m = cur;
    endtask

    task automatic step(input logic s, input logic [1:0] t);
        exp_t e;
        start  = s;
        target = t;
        @(posedge clk);
        if (idle_m && s) push_plan(int'(t));
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            idle_m = 1'b0;
        end else begin
            e = {4'h0, 1'b0, 1'b0, 2'(mdl_m), 1'b0};
            idle_m = 1'b1;
        end
        check("dout", 8'(dout), 8'(e.dout));
        check("busy", 8'(busy), 8'(e.busy));
        check("done", 8'(done), 8'(e.done));
        check("state_mdl", 8'(state_mdl), 8'(e.mdl));
        check("q_exp", q_exp, level_q(int'(e.mdl)));
        check("srst_out", 8'(srst_out), 8'(e.srst));
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst_in = 1'b1;
        #1;
        check("rst_dout", 8'(dout), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        check("rst_q_exp", q_exp, 8'h00);
        check("rst_srst", 8'(srst_out), 8'h00);
        q.delete();
        mdl_m  = 0;
        idle_m = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    initial begin
        logic [3:0] exp26 [7];
        errors = 0;
        checks = 0;
        mdl_m  = 0;
        idle_m = 1'b1;
        rst_in = 1'b0;
        start  = 1'b0;
        target = 2'd0;
        exp26  = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        do_reset();

        // s0 -> s2 two-code walk with fixed expected stream.
        for (int i = 0; i < 7; i++) begin
            step(i == 0, 2'd2);
            check("r26_dout", 8'(dout), 8'(exp26[i]));
            check("r26_done", 8'(done), (i == 6) ? 8'h01 : 8'h00);
            if (i >= 4) check("r26_qexp", q_exp, 8'hFF);
        end
        step(1'b1, 2'd3);
        step(1'b0, 2'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd1);

        // Abort a command in flight with reset.
        step(1'b1, 2'd2);
        step(1'b0, 2'd1);
        step(1'b0, 2'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0);
            check("abort_no_done", 8'(done), 8'h00);
        end

        // Randomized commands, interfering starts and occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            else step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end
        while (q.size() > 0) step(1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
